// File: rtl/cipher_tx.sv
// Serial framer for encrypted words: start, N data bits LSB first, even parity, stop; first bit leaves one cycle after the handshake.
// data_ready is high only in IDLE; words offered while a frame is in flight are dropped, never queued.
module cipher_tx #(
    parameter int N            = 16,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic         clock,
    input  logic         n_reset,
    input  logic [N-1:0] data_in,
    input  logic         data_valid,
    output logic         data_ready,
    output logic         tx,
    output logic         busy,
    output logic         tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]    state_q,   state_d;
    logic [N-1:0]  shift_q,   shift_d;
    logic [BW-1:0] bit_idx_q, bit_idx_d;
    logic [CW-1:0] baud_q,    baud_d;
    logic          parity_q,  parity_d;
    logic          tx_q,      tx_d;
    logic          busy_q,    busy_d;
    logic          ready_q,   ready_d;
    logic          done_q,    done_d;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        baud_d    = baud_q;
        parity_d  = parity_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (data_valid) begin
                    shift_d   = data_in;
                    parity_d  = ^data_in;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == BIT_LAST) begin
                        bit_idx_d = '0;
                        state_d   = PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered line changes on the bit boundary itself.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            baud_q    <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            baud_q    <= baud_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign data_ready = ready_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_cipher_tx.sv
// Randomized bench for cipher_tx: a frame-level model predicts acceptance and timing, a line monitor decodes frames.
module tb_cipher_tx;

    localparam int N     = 16;
    localparam int C     = 4;
    localparam int FRAME = (N + 3) * C;

    logic         clock = 1'b0;
    logic         n_reset = 1'b0;
    logic [N-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         data_ready;
    logic         tx;
    logic         busy;
    logic         tx_done;

    cipher_tx #(.N(N), .CLKS_PER_BIT(C)) dut (
        .clock      (clock),
        .n_reset    (n_reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Model state: edge counter, edge index of the last stop-bit cycle, accepted-word count.
    int  cyc = 0;
    int  model_end = 0;
    bit  frame_live = 1'b0;
    bit  started = 1'b0;
    bit  abort_flag = 1'b0;
    int  n_acc = 0;
    logic [N-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc + 1);
        end
    endtask

    // A word is taken when valid is high at an edge whose preceding cycle was idle in the model.
    always @(posedge clock) begin
        cyc++;
        if (!n_reset) begin
            started    = 1'b1;
            exp_q.delete();
            model_end  = cyc;
            frame_live = 1'b0;
            abort_flag = 1'b1;
        end else if (started && data_valid && (cyc - 1 >= model_end)) begin
            exp_q.push_back(data_in);
            model_end  = cyc + FRAME;
            frame_live = 1'b1;
            n_acc++;
        end
    end

    logic         smp[FRAME];
    int           idx = 0;
    bit           in_frame = 1'b0;
    bit           bsy;
    bit           stable;
    logic [N-1:0] got_w;
    logic [N-1:0] exp_w;

    always @(negedge clock) begin
        if (started) begin
            if (abort_flag) begin
                abort_flag = 1'b0;
                in_frame   = 1'b0;
            end
            bsy = (cyc < model_end);
            check("data_ready", 32'(data_ready), 32'(!bsy));
            check("busy", 32'(busy), 32'(bsy));
            check("tx_done", 32'(tx_done), 32'(frame_live && (cyc == model_end)));
            if (!bsy) check("idle_line", 32'(tx), 32'd1);

            if (!in_frame && tx === 1'b0) begin
                in_frame = 1'b1;
                idx      = 0;
            end
            if (in_frame) begin
                smp[idx] = tx;
                idx++;
                if (idx == FRAME) begin
                    in_frame = 1'b0;
                    stable   = 1'b1;
                    for (int s = 0; s < N + 3; s++)
                        for (int j = 1; j < C; j++)
                            if (smp[s*C+j] !== smp[s*C]) stable = 1'b0;
                    check("bit_hold", 32'(stable), 32'd1);
                    for (int i = 0; i < N; i++) got_w[i] = smp[(1+i)*C];
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame: got word %0h expected no frame (cycle %0d)", got_w, cyc + 1);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("frame_word", 32'(got_w), 32'(exp_w));
                        check("parity_bit", 32'(smp[(N+1)*C]), 32'(^exp_w));
                        check("stop_bit", 32'(smp[(N+2)*C]), 32'd1);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (data_ready !== 1'b1 && n < 3 * FRAME) begin
            tick();
            n++;
        end
        if (data_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: got data_ready=%b expected 1 within %0d cycles", data_ready, 3 * FRAME);
        end
    endtask

    task automatic wait_accept(input int target);
        int n = 0;
        while (n_acc < target && n < 3 * FRAME) begin
            tick();
            n++;
        end
        if (n_acc < target) begin
            checks++;
            failures++;
            $display("FAIL wait_accept: got %0d accepted expected %0d", n_acc, target);
        end
    endtask

    task automatic send(input logic [N-1:0] w, input bit scramble);
        wait_idle();
        data_valid = 1'b1;
        data_in    = w;
        wait_accept(n_acc + 1);
        data_valid = 1'b0;
        if (scramble) begin
            for (int i = 0; i < FRAME; i++) begin
                data_in = N'($urandom);
                tick();
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        n_reset = 1'b1;
        tick();

        send(16'h001C, 1'b0);
        send(16'h0000, 1'b0);
        send(16'hFFFF, 1'b0);
        send(16'h0001, 1'b0);

        // Back-to-back with valid held high: second word must go in the tx_done cycle.
        wait_idle();
        data_valid = 1'b1;
        data_in    = 16'hACE1;
        wait_accept(n_acc + 1);
        data_in    = 16'h1234;
        wait_accept(n_acc + 1);
        data_valid = 1'b0;

        // A word offered mid-frame must be dropped.
        send(16'h3C3C, 1'b0);
        repeat (20) tick();
        data_valid = 1'b1;
        data_in    = 16'hBEEF;
        tick();
        data_valid = 1'b0;

        // Reset during data bit 5, then a clean frame.
        send(16'hA5C3, 1'b0);
        repeat (6 * C + 1) tick();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        send(16'h7E81, 1'b0);

        // Reset and valid in the same cycle: no transfer.
        wait_idle();
        data_valid = 1'b1;
        data_in    = 16'h0F0F;
        n_reset    = 1'b0;
        tick();
        n_reset    = 1'b1;
        data_valid = 1'b0;
        tick();

        send(16'h5A5A, 1'b1);

        for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(N'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (FRAME + 5) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
